// File: rtl/oled_serial_rx.sv
// Receive-side decoder for the OLED 4-wire serial link: synchronises the pins, deserialises MSB-first bytes tagged with DC, and buffers them in a FIFO.
// Optional macro OLED_RX_TIMEOUT_EN discards stalled partial bytes after TIMEOUT_CYCLES idle clocks.
module oled_serial_rx #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          oled_nrst,
  input  logic                          oled_dc,
  input  logic [1:0]                    oled_d,
  output logic [8:0]                    m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          frame_err,
  output logic                          rst_seen,
  input  logic                          clr
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  localparam logic [1:0] ST_HOLD  = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES must be 2..4");
  end
  if (FIFO_DEPTH < 4 || FIFO_DEPTH > 256 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two in 4..256");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  // Pin synchronisers; NRST idles high so reset release cannot fake a falling edge
  logic [SYNC_STAGES-1:0] r_sync_sclk, r_sync_sdin, r_sync_dc, r_sync_nrst;
  logic w_sclk_s, w_sdin_s, w_dc_s, w_nrst_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync_sclk <= '0;
      r_sync_sdin <= '0;
      r_sync_dc   <= '0;
      r_sync_nrst <= '1;
    end else begin
      r_sync_sclk <= {r_sync_sclk[SYNC_STAGES-2:0], oled_d[0]};
      r_sync_sdin <= {r_sync_sdin[SYNC_STAGES-2:0], oled_d[1]};
      r_sync_dc   <= {r_sync_dc[SYNC_STAGES-2:0], oled_dc};
      r_sync_nrst <= {r_sync_nrst[SYNC_STAGES-2:0], oled_nrst};
    end
  end

  assign w_sclk_s = r_sync_sclk[SYNC_STAGES-1];
  assign w_sdin_s = r_sync_sdin[SYNC_STAGES-1];
  assign w_dc_s   = r_sync_dc[SYNC_STAGES-1];
  assign w_nrst_s = r_sync_nrst[SYNC_STAGES-1];

  // Edge detection; SDIN/DC are captured alongside the rise pulse so they align
  logic r_sclk_d, r_sclk_rise, r_sdin_q, r_dc_q, r_nrst_d, r_rst_seen;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_d    <= 1'b0;
      r_sclk_rise <= 1'b0;
      r_sdin_q    <= 1'b0;
      r_dc_q      <= 1'b0;
      r_nrst_d    <= 1'b1;
      r_rst_seen  <= 1'b0;
    end else begin
      r_sclk_d    <= w_sclk_s;
      r_sclk_rise <= w_sclk_s & ~r_sclk_d;
      r_sdin_q    <= w_sdin_s;
      r_dc_q      <= w_dc_s;
      r_nrst_d    <= w_nrst_s;
      r_rst_seen  <= r_nrst_d & ~w_nrst_s;
    end
  end

  logic [1:0] r_state, w_state_n;
  logic [7:0] r_sr, w_sr_n;
  logic [2:0] r_bit_cnt, w_bit_cnt_n;
  logic       r_push, w_push_n;
  logic [8:0] r_push_data, w_push_data_n;
  logic       w_frame_set;
`ifdef OLED_RX_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_to_cnt, w_to_cnt_n;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_sr        <= '0;
      r_bit_cnt   <= '0;
      r_push      <= 1'b0;
      r_push_data <= '0;
`ifdef OLED_RX_TIMEOUT_EN
      r_to_cnt    <= '0;
`endif
    end else begin
      r_state     <= w_state_n;
      r_sr        <= w_sr_n;
      r_bit_cnt   <= w_bit_cnt_n;
      r_push      <= w_push_n;
      r_push_data <= w_push_data_n;
`ifdef OLED_RX_TIMEOUT_EN
      r_to_cnt    <= w_to_cnt_n;
`endif
    end
  end

  // Next-state: NRST low overrides everything and silently drops any partial byte
  always_comb begin
    w_state_n     = r_state;
    w_sr_n        = r_sr;
    w_bit_cnt_n   = r_bit_cnt;
    w_push_n      = 1'b0;
    w_push_data_n = r_push_data;
    w_frame_set   = 1'b0;
`ifdef OLED_RX_TIMEOUT_EN
    w_to_cnt_n    = '0;
`endif
    if (!w_nrst_s) begin
      w_state_n   = ST_HOLD;
      w_sr_n      = '0;
      w_bit_cnt_n = '0;
    end else begin
      case (r_state)
        ST_HOLD: w_state_n = ST_IDLE;
        ST_IDLE, ST_SHIFT: begin
          if (r_sclk_rise) begin
            w_sr_n = {r_sr[6:0], r_sdin_q};
            if (r_bit_cnt == 3'd7) begin
              w_push_n      = 1'b1;
              w_push_data_n = {r_dc_q, r_sr[6:0], r_sdin_q};
              w_sr_n        = '0;
              w_bit_cnt_n   = '0;
              w_state_n     = ST_IDLE;
            end else begin
              w_bit_cnt_n = r_bit_cnt + 3'd1;
              w_state_n   = ST_SHIFT;
            end
          end
`ifdef OLED_RX_TIMEOUT_EN
          else if (r_state == ST_SHIFT) begin
            if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
              w_sr_n      = '0;
              w_bit_cnt_n = '0;
              w_state_n   = ST_IDLE;
              w_frame_set = 1'b1;
            end else begin
              w_to_cnt_n = r_to_cnt + TW'(1);
            end
          end
`endif
        end
        default: begin
          w_state_n   = ST_IDLE;
          w_sr_n      = '0;
          w_bit_cnt_n = '0;
        end
      endcase
    end
  end

  // Output FIFO; a push while full is only accepted if a pop frees the slot
  logic [8:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [LW-1:0] r_count, w_count_n;
  logic          r_tvalid, r_overflow, r_frame_err;
  logic          w_pop, w_full, w_wr_en, w_ovf_set;

  assign w_pop     = r_tvalid & m_tready;
  assign w_full    = (r_count == LW'(FIFO_DEPTH));
  assign w_wr_en   = r_push & (~w_full | w_pop);
  assign w_ovf_set = r_push & w_full & ~w_pop;
  assign w_count_n = r_count + LW'(w_wr_en) - LW'(w_pop);

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= r_push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_tvalid    <= 1'b0;
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count     <= w_count_n;
      r_tvalid    <= (w_count_n != '0);
      r_overflow  <= w_ovf_set | (r_overflow & ~clr);
      r_frame_err <= w_frame_set | (r_frame_err & ~clr);
    end
  end

  assign m_tdata    = r_tvalid ? r_mem[r_rd_ptr] : 9'd0;
  assign m_tvalid   = r_tvalid;
  assign fifo_level = r_count;
  assign overflow   = r_overflow;
  assign frame_err  = r_frame_err;
  assign rst_seen   = r_rst_seen;

endmodule
